// File: rtl/biss_ma_sequencer_pkg.sv
// Shared definitions for the BiSS-C MA frame sequencer: FSM state encoding,
// completion error codes and the default ACK/start search window.
package biss_ma_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK   = 3'd1,
    ST_START = 3'd2,
    ST_CDS   = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5,
    ST_TMO   = 3'd6,
    ST_DONE  = 3'd7
  } biss_state_e;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_NOACK = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;

  localparam int unsigned MAX_ACK_CYC_DEF = 16;

endpackage

// File: rtl/biss_ma_tick.sv
// MA half-period timer: toggles the MA level every hp clocks and flags the
// last clock of each high half as the SLO sample point.
module biss_ma_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             launch_i,
  input  logic             halt_i,
  input  logic [DIV_W-1:0] hp_i,
  output logic             ma_o,
  output logic             strobe_o
);

  logic [DIV_W-1:0] cnt_r;
  logic             ma_r;
  logic             run_r;

  assign ma_o     = ma_r;
  assign strobe_o = run_r & ma_r & (cnt_r == hp_i);

  // Half-period counter 1..hp; launch starts with the low half, halt parks MA high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= '0;
      ma_r  <= 1'b1;
      run_r <= 1'b0;
    end else if (launch_i) begin
      cnt_r <= DIV_W'(1);
      ma_r  <= 1'b0;
      run_r <= 1'b1;
    end else if (halt_i) begin
      cnt_r <= '0;
      ma_r  <= 1'b1;
      run_r <= 1'b0;
    end else if (run_r) begin
      if (cnt_r == hp_i) begin
        cnt_r <= DIV_W'(1);
        ma_r  <= ~ma_r;
      end else begin
        cnt_r <= cnt_r + DIV_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
      ma_r  <= 1'b1;
    end
  end

endmodule

// File: rtl/biss_ma_sequencer.sv
// BiSS-C master frame sequencer: drives one gated MA burst per start request,
// decodes ACK/start/CDS on SLO, shifts in the data field and supervises timeout.
module biss_ma_sequencer
  import biss_ma_sequencer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DIV_W       = 16,
  parameter int TO_W        = 20,
  parameter int MAX_ACK_CYC = MAX_ACK_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DIV_W-1:0]  half_period_i,
  input  logic [5:0]        frame_bits_i,
  input  logic [TO_W-1:0]   timeout_i,
  input  logic              slo_i,
  output logic              ma_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o,
  output logic              cds_o,
  output logic [1:0]        err_o
);

  localparam int NB_W = ($clog2(DATA_W + 1) > 6) ? $clog2(DATA_W + 1) : 6;
  localparam int AC_W = $clog2(MAX_ACK_CYC + 2);
  localparam logic [AC_W-1:0] MAX_ACK_V = AC_W'(MAX_ACK_CYC);

  biss_state_e       state_r;
  logic [DIV_W-1:0]  hp_r, hp_clamp_s;
  logic [NB_W-1:0]   nbits_r, nbits_clamp_s, fb_ext_s, bit_cnt_r, bit_next_s;
  logic [AC_W-1:0]   ack_cnt_r, ack_next_s;
  logic [TO_W-1:0]   tmo_cnt_r, tmo_next_s;
  logic              slo_meta_r, slo_sync_r;
  logic [DATA_W-1:0] data_r;
  logic              cds_r, busy_r, done_r, noack_r;
  logic [1:0]        err_r;
  logic              launch_s, halt_s, burst_s, stop_now_s, noack_now_s;
  logic              strobe_s, ma_s;

  biss_ma_tick #(.DIV_W(DIV_W)) u_tick (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .launch_i (launch_s),
    .halt_i   (halt_s),
    .hp_i     (hp_r),
    .ma_o     (ma_s),
    .strobe_o (strobe_s)
  );

  assign ma_o   = ma_s;
  assign busy_o = busy_r;
  assign done_o = done_r;
  assign data_o = data_r;
  assign cds_o  = cds_r;
  assign err_o  = err_r;

  // Frame configuration as it will be latched on start acceptance.
  always_comb begin
    fb_ext_s = NB_W'(frame_bits_i);
    if (half_period_i < DIV_W'(2)) begin
      hp_clamp_s = DIV_W'(2);
    end else begin
      hp_clamp_s = half_period_i;
    end
    if (fb_ext_s == NB_W'(0)) begin
      nbits_clamp_s = NB_W'(1);
    end else if (fb_ext_s > NB_W'(DATA_W)) begin
      nbits_clamp_s = NB_W'(DATA_W);
    end else begin
      nbits_clamp_s = fb_ext_s;
    end
  end

  // Burst-end decisions taken on a sample strobe; a stop parks MA high at the
  // end of the current high half instead of starting another low half.
  always_comb begin
    ack_next_s  = ack_cnt_r + AC_W'(1);
    bit_next_s  = bit_cnt_r + NB_W'(1);
    tmo_next_s  = tmo_cnt_r + TO_W'(1);
    launch_s    = (state_r == ST_IDLE) & start_i;
    burst_s     = (state_r == ST_ACK) | (state_r == ST_START) |
                  (state_r == ST_CDS) | (state_r == ST_DATA);
    noack_now_s = 1'b0;
    case (state_r)
      ST_ACK: begin
        if (strobe_s && slo_sync_r && (ack_next_s >= MAX_ACK_V)) begin
          noack_now_s = 1'b1;
        end else begin
          noack_now_s = 1'b0;
        end
      end
      ST_START: begin
        if (strobe_s && !slo_sync_r && (ack_next_s > MAX_ACK_V)) begin
          noack_now_s = 1'b1;
        end else begin
          noack_now_s = 1'b0;
        end
      end
      default: noack_now_s = 1'b0;
    endcase
    if ((state_r == ST_DATA) && strobe_s && (bit_next_s == nbits_r)) begin
      stop_now_s = 1'b1;
    end else begin
      stop_now_s = noack_now_s;
    end
    halt_s = stop_now_s | ~burst_s;
  end

  // Two-stage synchronizer for the asynchronous SLO line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slo_meta_r <= 1'b1;
      slo_sync_r <= 1'b1;
    end else begin
      slo_meta_r <= slo_i;
      slo_sync_r <= slo_meta_r;
    end
  end

  // Frame FSM with registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= ST_IDLE;
      hp_r      <= '0;
      nbits_r   <= '0;
      bit_cnt_r <= '0;
      ack_cnt_r <= '0;
      tmo_cnt_r <= '0;
      data_r    <= '0;
      cds_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      noack_r   <= 1'b0;
      err_r     <= ERR_OK;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_i) begin
            state_r   <= ST_ACK;
            busy_r    <= 1'b1;
            data_r    <= '0;
            cds_r     <= 1'b0;
            hp_r      <= hp_clamp_s;
            nbits_r   <= nbits_clamp_s;
            bit_cnt_r <= '0;
            ack_cnt_r <= '0;
            tmo_cnt_r <= '0;
            noack_r   <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACK: begin
          if (strobe_s) begin
            ack_cnt_r <= ack_next_s;
            if (!slo_sync_r) begin
              state_r <= ST_START;
            end else if (noack_now_s) begin
              noack_r <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              state_r <= ST_ACK;
            end
          end else begin
            state_r <= ST_ACK;
          end
        end
        ST_START: begin
          if (strobe_s) begin
            ack_cnt_r <= ack_next_s;
            if (slo_sync_r) begin
              state_r <= ST_CDS;
            end else if (noack_now_s) begin
              noack_r <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              state_r <= ST_START;
            end
          end else begin
            state_r <= ST_START;
          end
        end
        ST_CDS: begin
          if (strobe_s) begin
            cds_r   <= slo_sync_r;
            state_r <= ST_DATA;
          end else begin
            state_r <= ST_CDS;
          end
        end
        ST_DATA: begin
          if (strobe_s) begin
            data_r    <= {data_r[DATA_W-2:0], slo_sync_r};
            bit_cnt_r <= bit_next_s;
            if (stop_now_s) begin
              state_r <= ST_STOP;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_STOP: begin
          if (noack_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            err_r   <= ERR_NOACK;
          end else begin
            state_r   <= ST_TMO;
            tmo_cnt_r <= '0;
          end
        end
        ST_TMO: begin
          if (slo_sync_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            err_r   <= ERR_OK;
          end else if ((timeout_i != '0) && (tmo_next_s == timeout_i)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            err_r   <= ERR_TMO;
          end else begin
            tmo_cnt_r <= tmo_next_s;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
